// File: rtl/mem_arbiter_pkg.sv
// Shared types, widths and command decode for the two-port RAM arbiter.
package mem_arbiter_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ADDR_W     = 9;
    localparam int unsigned RAM_ADDR_W = ADDR_W - 1;
    localparam int unsigned PERF_W     = 16;
    localparam int unsigned PERF_SUM_W = PERF_W + 1;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    // Transaction attributes still needed after the RAM has been addressed.
    typedef struct packed {
        cmd_e cmd;
        logic off_ram;
        logic id;
    } txn_t;

    // The reserved encoding 2'b11 behaves as MNONE.
    function automatic cmd_e decode_cmd(input logic [1:0] raw);
        case (raw)
            2'b01:   return MREAD;
            2'b10:   return MWRITE;
            default: return MNONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: combinational, the previous winner loses a tie.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    output logic       gnt_id_o,
    output logic       gnt_valid_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = 1'b0;
        case (req_i)
            2'b10:   gnt_id_o = 1'b1;
            2'b11:   gnt_id_o = ~rr_last_i;
            default: gnt_id_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one registered-read 256x16 RAM between two requesters, one transaction at a time.
// Optional MEM_ARB_PERF_EN adds a saturating perf_wait counter of requester wait cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [1:0]            cmd0,
    input  logic [1:0]            cmd1,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_din,
    input  logic [DATA_W-1:0]     ram_dout
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0]     perf_wait
`endif
);

    state_e                  state_q, state_d;
    txn_t                    txn_q, txn_d;
    logic                    rr_last_q, rr_last_d;
    logic                    ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d, ram_write_q, ram_write_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d, ram_din_q, ram_din_d;
    logic [RAM_ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                    gnt_id, gnt_valid;
    cmd_e                    sel_cmd;
    logic [ADDR_W-1:0]       sel_addr;

    rr_arbiter2 u_rr (
        .req_i       ({req1, req0}),
        .rr_last_i   (rr_last_q),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_valid)
    );

    assign sel_cmd  = decode_cmd(gnt_id ? cmd1 : cmd0);
    assign sel_addr = gnt_id ? addr1 : addr0;

    // RAM controls are registered on capture so they are stable for the whole ISSUE cycle.
    always_comb begin
        state_d     = state_q;
        txn_d       = txn_q;
        rr_last_d   = rr_last_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = '0;
        ram_write_d = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_valid) begin
                    txn_d.cmd     = sel_cmd;
                    txn_d.off_ram = sel_addr[ADDR_W-1];
                    txn_d.id      = gnt_id;
                    rr_last_d     = gnt_id;
                    ram_addr_d    = sel_addr[RAM_ADDR_W-1:0];
                    ram_din_d     = gnt_id ? wdata1 : wdata0;
                    ram_write_d   = (sel_cmd == MWRITE) && !sel_addr[ADDR_W-1];
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_RESP;
            S_RESP: begin
                ack0_d  = (txn_q.id == 1'b0);
                ack1_d  = (txn_q.id == 1'b1);
                err_d   = txn_q.off_ram;
                rdata_d = (txn_q.cmd == MREAD && !txn_q.off_ram) ? ram_dout : '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            txn_q       <= '0;
            rr_last_q   <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            ram_write_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            txn_q       <= txn_d;
            rr_last_q   <= rr_last_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            ram_write_q <= ram_write_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign ram_write = ram_write_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;

`ifdef MEM_ARB_PERF_EN
    logic [PERF_W-1:0]     perf_q, perf_d;
    logic [1:0]            wait_inc;
    logic                  busy;
    logic [PERF_SUM_W-1:0] perf_sum;

    // A requester is in service only while its own transaction occupies ISSUE/RESP.
    always_comb begin
        busy     = (state_q != S_IDLE);
        wait_inc = 2'd0;
        if (req0 && !(busy && txn_q.id == 1'b0)) wait_inc = wait_inc + 2'd1;
        if (req1 && !(busy && txn_q.id == 1'b1)) wait_inc = wait_inc + 2'd1;
        perf_sum = {1'b0, perf_q} + PERF_SUM_W'(wait_inc);
        perf_d   = perf_sum[PERF_W] ? '1 : perf_sum[PERF_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_wait = perf_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 256x16 registered-read RAM.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [1:0]  cmd0, cmd1;
    logic [8:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1, err, ram_write;
    logic [15:0] rdata, ram_din, ram_dout;
    logic [7:0]  ram_addr;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] perf_wait;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    logic [15:0] mem [256];

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef MEM_ARB_PERF_EN
        , .perf_wait(perf_wait)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write) begin
            mem[ram_addr] <= ram_din;
            wr_cnt = wr_cnt + 1;
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits up to 12 cycles for an ack; optionally drops that requester within the ack cycle.
    task automatic wait_ack(input bit drop, output int who, output logic [15:0] rd,
                            output logic e, output int n);
        who = -1; rd = '0; e = 1'b0; n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                who = ack0 ? 0 : 1;
                rd  = rdata;
                e   = err;
                n   = i;
                if (drop && ack0) req0 = 1'b0;
                if (drop && ack1) req1 = 1'b0;
                break;
            end
        end
    endtask

    task automatic drive(input int id, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        if (id == 0) begin req0 = 1'b1; cmd0 = c; addr0 = a; wdata0 = d; end
        else         begin req1 = 1'b1; cmd1 = c; addr1 = a; wdata1 = d; end
    endtask

    initial begin
        int who, n, wr0;
        logic [15:0] rd, old7;
        logic e;
        int seq [4];

        reset = 1'b1;
        req0 = 0; req1 = 0; cmd0 = 0; cmd1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (2) @(negedge clk);
        check("rst_ack0", 32'(ack0), 0);
        check("rst_ack1", 32'(ack1), 0);
        check("rst_err", 32'(err), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_ram_write", 32'(ram_write), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_din", 32'(ram_din), 0);
`ifdef MEM_ARB_PERF_EN
        check("rst_perf", 32'(perf_wait), 0);
`endif
        reset = 1'b0;

        // Write 0x005 <- ABCD, stepping through ISSUE/RESP/ack cycles.
        @(negedge clk);
        drive(0, 2'b10, 9'h005, 16'hABCD);
        @(negedge clk);
        check("wr_issue_we", 32'(ram_write), 1);
        check("wr_issue_addr", 32'(ram_addr), 32'h05);
        check("wr_issue_din", 32'(ram_din), 32'hABCD);
        @(negedge clk);
        check("wr_resp_noack", 32'(ack0), 0);
        check("wr_resp_we_low", 32'(ram_write), 0);
        @(negedge clk);
        check("wr_ack0", 32'(ack0), 1);
        check("wr_ack1", 32'(ack1), 0);
        check("wr_err", 32'(err), 0);
        check("wr_rdata", 32'(rdata), 0);
        req0 = 1'b0;
        check("wr_mem5", 32'(mem[5]), 32'hABCD);

        // Read back the same address.
        @(negedge clk);
        drive(0, 2'b01, 9'h005, 16'h0000);
        wait_ack(1, who, rd, e, n);
        check("rd_who", 32'(who), 0);
        check("rd_lat", 32'(n), 3);
        check("rd_data", 32'(rd), 32'hABCD);
        check("rd_err", 32'(e), 0);

        // Reserved command 11: full pass, zero data, no write.
        @(negedge clk);
        wr0 = wr_cnt;
        drive(0, 2'b11, 9'h005, 16'h1111);
        wait_ack(1, who, rd, e, n);
        check("none_who", 32'(who), 0);
        check("none_lat", 32'(n), 3);
        check("none_rdata", 32'(rd), 0);
        check("none_nowrite", 32'(wr_cnt - wr0), 0);
        check("none_mem5", 32'(mem[5]), 32'hABCD);

        // Preload 0x006 from requester 1.
        @(negedge clk);
        drive(1, 2'b10, 9'h006, 16'h1234);
        wait_ack(1, who, rd, e, n);
        check("wr6_who", 32'(who), 1);
        check("wr6_mem", 32'(mem[6]), 32'h1234);

        // After reset both read together: req0 first, then req1.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 2'b01, 9'h005, 16'h0);
        drive(1, 2'b01, 9'h006, 16'h0);
        wait_ack(1, who, rd, e, n);
        check("arb_first_who", 32'(who), 0);
        check("arb_first_data", 32'(rd), 32'hABCD);
`ifdef MEM_ARB_PERF_EN
        check("perf_first_ack", 32'(perf_wait), 4);
`endif
        wait_ack(1, who, rd, e, n);
        check("arb_second_who", 32'(who), 1);
        check("arb_second_data", 32'(rd), 32'h1234);

        // Both held: strict alternation starting with req0.
        @(negedge clk);
        drive(0, 2'b01, 9'h005, 16'h0);
        drive(1, 2'b01, 9'h006, 16'h0);
        for (int k = 0; k < 4; k++) begin
            wait_ack(0, who, rd, e, n);
            seq[k] = who;
            check($sformatf("alt_data%0d", k), 32'(rd), (k % 2 == 0) ? 32'hABCD : 32'h1234);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        for (int k = 0; k < 4; k++)
            check($sformatf("alt_who%0d", k), 32'(seq[k]), 32'(k % 2));

        // Off-RAM write: error, no RAM write.
        @(negedge clk);
        wr0 = wr_cnt;
        drive(1, 2'b10, 9'h105, 16'h5555);
        wait_ack(1, who, rd, e, n);
        check("off_wr_who", 32'(who), 1);
        check("off_wr_err", 32'(e), 1);
        check("off_wr_nowrite", 32'(wr_cnt - wr0), 0);
        check("off_wr_mem5", 32'(mem[5]), 32'hABCD);

        // Off-RAM read: error, zero data even though RAM[5] is nonzero.
        @(negedge clk);
        drive(1, 2'b01, 9'h105, 16'h0);
        wait_ack(1, who, rd, e, n);
        check("off_rd_err", 32'(e), 1);
        check("off_rd_data", 32'(rd), 0);

        // Reset during ISSUE of a write.
        @(negedge clk);
        old7 = mem[7];
        drive(0, 2'b10, 9'h007, 16'h7777);
        @(negedge clk);
        check("rstmid_we_before", 32'(ram_write), 1);
        reset = 1'b1;
        req0  = 1'b0;
        #1;
        check("rstmid_we_async", 32'(ram_write), 0);
        check("rstmid_addr", 32'(ram_addr), 0);
        check("rstmid_din", 32'(ram_din), 0);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack0 || ack1) n++;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack0 || ack1) n++;
        end
        check("rstmid_noack", 32'(n), 0);
        check("rstmid_mem7", 32'(mem[7]), 32'(old7));

        // RAM contents survive reset.
        drive(0, 2'b01, 9'h005, 16'h0);
        wait_ack(1, who, rd, e, n);
        check("post_rst_who", 32'(who), 0);
        check("post_rst_data", 32'(rd), 32'hABCD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
